// File: rtl/bias_add_stage.sv
// bias_add_stage: adds a packed per-lane bias to each adder-tree result, saturates the sum
// to 18-bit signed and forwards it over valid/ready, tagging the last vector of each frame.
// Two-stage pipeline: S1 registers the 19-bit sums, S2 saturates and drives the outputs.
// Optional build macro BIAS_ADD_RELU_EN: clamp negative saturated results to zero in S2.
module bias_add_stage #(
    parameter int unsigned N_adder_tree = 16,
    parameter int unsigned FRAME_LEN    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_adder_tree*18-1:0] bias_q,
    input  logic [N_adder_tree*18-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N_adder_tree*18-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [N_adder_tree-1:0]    sat_flag
);

    localparam int unsigned W = N_adder_tree * 18;
    localparam logic [15:0] LastIdx = 16'(FRAME_LEN - 1);

    logic                          s1_valid_q, s1_valid_d;
    logic [N_adder_tree-1:0][18:0] s1_sum_q, s1_sum_d;
    logic                          s1_last_q, s1_last_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          out_valid_q, out_valid_d;
    logic [W-1:0]                  out_data_q, out_data_d;
    logic                          out_last_q, out_last_d;
    logic [N_adder_tree-1:0]       sat_q, sat_d;

    logic                          s2_advance;
    logic                          accept;
    logic [W-1:0]                  sat_data;
    logic [N_adder_tree-1:0]       sat_bits;

    // Handshake: a stage moves when the one after it is empty or draining this cycle.
    always_comb begin
        s2_advance = !out_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_advance;
        accept     = in_valid && in_ready;
    end

    // S1 next state: widen and add each lane, tag frame-last, step the frame counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_last_d  = s1_last_q;
        cnt_d      = cnt_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            for (int i = 0; i < int'(N_adder_tree); i++) begin
                s1_sum_d[i] = {in_data[18*i+17], in_data[18*i +: 18]}
                            + {bias_q[18*i+17], bias_q[18*i +: 18]};
            end
            s1_last_d = (cnt_q == LastIdx);
            cnt_d     = (cnt_q == LastIdx) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    // Saturate each 19-bit sum; overflow shows as the top two bits disagreeing.
    always_comb begin
        sat_data = '0;
        sat_bits = '0;
        for (int i = 0; i < int'(N_adder_tree); i++) begin
            if (s1_sum_q[i][18] != s1_sum_q[i][17]) begin
                sat_bits[i]           = 1'b1;
                sat_data[18*i +: 18]  = s1_sum_q[i][18] ? 18'h20000 : 18'h1FFFF;
            end else begin
                sat_data[18*i +: 18]  = s1_sum_q[i][17:0];
            end
`ifdef BIAS_ADD_RELU_EN
            if (sat_data[18*i+17]) begin
                sat_data[18*i +: 18] = '0;
            end
`endif
        end
    end

    // S2 next state: load from S1 only when the output register is free or being taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sat_data;
                out_last_d = s1_last_q;
                sat_d      = sat_bits;
            end
        end
    end

    // Pipeline and counter state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_last_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_last_q   <= s1_last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_bias_add_stage.sv
// Self-checking bench for bias_add_stage: directed lane table, frame tagging, backpressure,
// mid-stream reset and a random stream, all checked against a saturating-add scoreboard.
module tb_bias_add_stage;

    localparam int unsigned N  = 16;
    localparam int unsigned FL = 4;
    localparam int unsigned W  = N * 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] bias_q = '0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic [N-1:0] sat_flag;

    bias_add_stage #(
        .N_adder_tree(N),
        .FRAME_LEN   (FL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bias_q   (bias_q),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] sat;
        logic         last;
    } exp_t;

    typedef struct {
        int lane;
        int din;
        int bias;
        int exp;
        bit sat;
    } vec_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           mcnt = 0;
    int           n_out = 0;
    logic [63:0]  lastmask = '0;
    bit           acc = 0;
    bit           emitted = 0;
    bit           saw_not_ready = 0;
    bit           stall_prev = 0;
    logic [W-1:0] held_data;
    logic         held_last;
    logic [N-1:0] held_sat;
    logic [W-1:0] obs_data;
    logic [N-1:0] obs_sat;
    int           cyc = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: independent integer saturating add per lane.
    function automatic exp_t model(input logic [W-1:0] d, input logic [W-1:0] b, input bit last);
        exp_t r;
        int   s;
        r.data = '0;
        r.sat  = '0;
        r.last = last;
        for (int i = 0; i < int'(N); i++) begin
            s = int'($signed(d[18*i +: 18])) + int'($signed(b[18*i +: 18]));
            if (s > 131071) begin
                s = 131071;
                r.sat[i] = 1'b1;
            end else if (s < -131072) begin
                s = -131072;
                r.sat[i] = 1'b1;
            end
`ifdef BIAS_ADD_RELU_EN
            if (s < 0) s = 0;
`endif
            r.data[18*i +: 18] = s[17:0];
        end
        return r;
    endfunction

    // Observe one cycle at the falling edge: scoreboard pops/pushes and stall stability.
    task automatic sample();
        exp_t e;
        acc     = 0;
        emitted = 0;
        if (rst) begin
            sb.delete();
            mcnt       = 0;
            stall_prev = 0;
            return;
        end
        if (stall_prev) begin
            check("stall_data", out_data, held_data);
            check("stall_last", W'(out_last), W'(held_last));
            check("stall_sat", W'(sat_flag), W'(held_sat));
        end
        if (out_valid && out_ready) begin
            emitted = 1;
            if (sb.size() == 0) begin
                check("unexpected_output", W'(1), W'(0));
            end else begin
                e = sb.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_sat", W'(sat_flag), W'(e.sat));
                check("sb_last", W'(out_last), W'(e.last));
            end
            if (n_out < 64) lastmask[n_out] = out_last;
            n_out++;
            obs_data = out_data;
            obs_sat  = sat_flag;
        end
        if (in_valid && in_ready) begin
            acc = 1;
            sb.push_back(model(in_data, bias_q, mcnt == int'(FL) - 1));
            mcnt = (mcnt == int'(FL) - 1) ? 0 : mcnt + 1;
        end
        if (!in_ready) saw_not_ready = 1;
        stall_prev = out_valid && !out_ready;
        held_data  = out_data;
        held_last  = out_last;
        held_sat   = sat_flag;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        logic [31:0]  r;
        for (int i = 0; i < int'(N); i++) begin
            r = $urandom();
            v[18*i +: 18] = r[17:0];
        end
        return v;
    endfunction

    // mode 0: full rate, 1: out_ready low on cycles 3..6, 2: random valid/ready.
    task automatic run_stream(input int nvec, input int mode, input int maxcyc);
        int sent = 0;
        cyc = 0;
        in_valid = 1'b0;
        while ((sent < nvec || sb.size() > 0) && cyc < maxcyc) begin
            if (!in_valid && sent < nvec && (mode != 2 || $urandom_range(9) < 7)) begin
                in_data  = rand_vec();
                bias_q   = rand_vec();
                in_valid = 1'b1;
            end
            out_ready = (mode == 1) ? !(cyc >= 3 && cyc <= 6)
                      : (mode == 2) ? ($urandom_range(9) < 7) : 1'b1;
            step();
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= maxcyc) check("stream_timeout", W'(cyc), W'(0));
        check("stream_sent", W'(sent), W'(nvec));
        check("stream_sb_empty", W'(sb.size()), W'(0));
    endtask

    initial begin
        vec_t         tbl[9];
        logic [W-1:0] vin;
        logic [W-1:0] vb;
        int           t;
        int           lat;
        int           l;

        tbl[0] = '{0, 100, -7068, -6968, 0};
        tbl[1] = '{3, 131000, 1000, 131071, 1};
        tbl[2] = '{5, -131000, -1000, -131072, 1};
        tbl[3] = '{7, 131071, 0, 131071, 0};
        tbl[4] = '{9, -131072, -1, -131072, 1};
        tbl[5] = '{15, -5, 3, -2, 0};
        tbl[6] = '{1, 131071, -131072, -1, 0};
        tbl[7] = '{2, 65536, 65535, 131071, 0};
        tbl[8] = '{4, 65536, 65536, 131071, 1};
`ifdef BIAS_ADD_RELU_EN
        for (int k = 0; k < 9; k++) if (tbl[k].exp < 0) tbl[k].exp = 0;
`endif

        do_reset();
        step();
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_last", W'(out_last), W'(0));
        check("rst_sat_flag", W'(sat_flag), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", W'(in_ready), W'(1));

        // Directed lanes: one vector at a time through an empty pipeline.
        for (int k = 0; k < 9; k++) begin
            vin = '0;
            vb  = '0;
            l   = tbl[k].lane;
            t   = tbl[k].din;
            vin[18*l +: 18] = t[17:0];
            t   = tbl[k].bias;
            vb[18*l +: 18] = t[17:0];
            in_data   = vin;
            bias_q    = vb;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            t = 0;
            do begin
                step();
                t++;
            end while (!acc && t < 10);
            in_valid = 1'b0;
            if (!acc) check("tbl_accept_timeout", W'(t), W'(0));
            lat = 0;
            do begin
                step();
                lat++;
            end while (!emitted && lat < 10);
            check("tbl_latency", W'(lat), W'(2));
            t = tbl[k].exp;
            check("tbl_lane", W'(obs_data[18*l +: 18]), W'(t[17:0]));
            check("tbl_sat", W'(obs_sat), W'(tbl[k].sat) << l);
        end

        // Frame tagging from a fresh frame; 12 vectors show the counter keeps wrapping.
        do_reset();
        n_out    = 0;
        lastmask = '0;
        run_stream(12, 0, 100);
        check("frame_throughput", W'(cyc), W'(14));
        check("frame_lastmask", W'(lastmask[11:0]), W'(12'h888));

        // Reset with two vectors in flight: they vanish and the next frame restarts.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_vec();
        step();
        check("mid_acc0", W'(acc), W'(1));
        in_data = rand_vec();
        step();
        check("mid_acc1", W'(acc), W'(1));
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mid_no_output", W'(out_valid), W'(0));
        end
        n_out    = 0;
        lastmask = '0;
        run_stream(4, 0, 50);
        check("mid_new_frame", W'(lastmask[3:0]), W'(4'b1000));

        // Backpressure window must fill the pipe and drop in_ready.
        saw_not_ready = 0;
        n_out = 0;
        run_stream(10, 1, 100);
        check("bp_outputs", W'(n_out), W'(10));
        check("bp_in_ready_dropped", W'(saw_not_ready), W'(1));

        // Random traffic.
        n_out = 0;
        run_stream(1000, 2, 30000);
        check("rand_outputs", W'(n_out), W'(1000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
